ultrasonic_ranger: RTL and testbench

Drives one HC-SR04-class ultrasonic sensor: issues a trigger pulse on request, times the returned echo, converts its width to whole centimetres and presents the result with a one-cycle `done` strobe. It sits directly upstream of the bottle classification/counting stage, which consumes `distance_out` and `done`. One measurement per `start` request. A mandatory hold-off enforces the sensor's minimum cycle time.

---
 rtl/ultrasonic_ranger.sv | 215 +++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04-class trigger/echo timer with centimetre conversion.
// Optional macro RANGER_GLITCH_FILTER_EN: requires the synchronised echo to hold
// a new level for 4 consecutive cycles before an edge is recognised.
module ultrasonic_ranger #(
    parameter int unsigned CLKS_PER_US = 50,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned TIMEOUT_US  = 30000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic [11:0] distance_out,
    output logic        done,
    output logic        timeout,
    output logic        busy
);

    localparam int unsigned MAX_A  = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
    localparam int unsigned MAX_US = (MAX_A > TRIG_US) ? MAX_A : TRIG_US;
    localparam int unsigned US_W   = $clog2(MAX_US + 1);
    localparam int unsigned PRE_W  = $clog2(CLKS_PER_US) + 1;
    localparam int unsigned SUB_W  = $clog2(US_PER_CM) + 1;
    localparam logic [11:0] CM_SAT = 12'hFFE;
    localparam logic [11:0] CM_TO  = 12'hFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_FINISH,
        S_HOLDOFF
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRE_W-1:0]   r_pre;
    logic [US_W-1:0]    r_us;
    logic [SUB_W-1:0]   r_sub;
    logic [SUB_W-1:0]   w_sub_nxt;
    logic [11:0]        r_cm;
    logic [11:0]        w_cm_nxt;
    logic [11:0]        r_dist;
    logic [11:0]        w_dist_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               r_trig;
    logic               r_done;
    logic               r_busy;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_echo_d;
    logic               w_echo_s;
    logic               w_rise;
    logic               w_fall;
    logic               w_tick;
    logic               w_entry;

    // Two-flop synchroniser for the asynchronous echo line, plus edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_echo_d <= 1'b0;
        end else begin
            r_sync1  <= echo;
            r_sync2  <= r_sync1;
            r_echo_d <= w_echo_s;
        end
    end

`ifdef RANGER_GLITCH_FILTER_EN
    logic       r_filt;
    logic [1:0] r_fcnt;

    // Accept a new echo level only after it has been stable for 4 cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_fcnt <= 2'd0;
        end else if (r_sync2 != r_filt) begin
            if (r_fcnt == 2'd3) begin
                r_filt <= r_sync2;
                r_fcnt <= 2'd0;
            end else begin
                r_fcnt <= r_fcnt + 2'd1;
            end
        end else begin
            r_fcnt <= 2'd0;
        end
    end

    assign w_echo_s = r_filt;
`else
    assign w_echo_s = r_sync2;
`endif

    assign w_rise  = w_echo_s & ~r_echo_d;
    assign w_fall  = ~w_echo_s & r_echo_d;
    assign w_tick  = (r_pre == PRE_W'(CLKS_PER_US - 1));
    assign w_entry = (w_state_nxt != r_state);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, centimetre conversion and result selection
    always_comb begin
        w_state_nxt   = r_state;
        w_sub_nxt     = r_sub;
        w_cm_nxt      = r_cm;
        w_dist_nxt    = r_dist;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                if (w_tick && (r_us == US_W'(TRIG_US - 1))) begin
                    w_state_nxt = S_WAIT_ECHO;
                end
            end
            S_WAIT_ECHO: begin
                if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                end else if (w_tick && (r_us == US_W'(TIMEOUT_US - 1))) begin
                    w_state_nxt   = S_FINISH;
                    w_dist_nxt    = CM_TO;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_MEASURE: begin
                // The tick landing in the falling-edge cycle still counts toward the result
                if (w_tick) begin
                    if (r_sub == SUB_W'(US_PER_CM - 1)) begin
                        w_sub_nxt = '0;
                        w_cm_nxt  = (r_cm == CM_SAT) ? r_cm : r_cm + 12'd1;
                    end else begin
                        w_sub_nxt = r_sub + SUB_W'(1);
                    end
                end
                if (w_fall) begin
                    w_state_nxt   = S_FINISH;
                    w_dist_nxt    = w_cm_nxt;
                    w_timeout_nxt = 1'b0;
                end else if (w_tick && (r_us == US_W'(TIMEOUT_US - 1))) begin
                    w_state_nxt   = S_FINISH;
                    w_dist_nxt    = CM_TO;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (w_tick && (r_us == US_W'(HOLDOFF_US - 1))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Prescaler, per-state microsecond counter and conversion counters; all cleared on state entry
    always_ff @(posedge clk) begin
        if (rst || w_entry) begin
            r_pre <= '0;
            r_us  <= '0;
            r_sub <= '0;
            r_cm  <= '0;
        end else if (r_state != S_IDLE) begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_us  <= w_tick ? r_us + US_W'(1) : r_us;
            r_sub <= w_sub_nxt;
            r_cm  <= w_cm_nxt;
        end
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_dist    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_trig    <= (w_state_nxt == S_TRIG);
            r_done    <= (w_state_nxt == S_FINISH);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_dist    <= w_dist_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign trig         = r_trig;
    assign done         = r_done;
    assign busy         = r_busy;
    assign distance_out = r_dist;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger, run with shortened timing parameters.
module tb_ultrasonic_ranger;

    localparam int unsigned CLKS_PER_US = 2;
    localparam int unsigned TRIG_US     = 10;
    localparam int unsigned US_PER_CM   = 58;
    localparam int unsigned TIMEOUT_US  = 3000;
    localparam int unsigned HOLDOFF_US  = 500;

    logic        clk;
    logic        rst;
    logic        start;
    logic        echo;
    logic        trig;
    logic [11:0] distance_out;
    logic        done;
    logic        timeout;
    logic        busy;

    int n_checks;
    int n_errors;

    ultrasonic_ranger #(
        .CLKS_PER_US (CLKS_PER_US),
        .TRIG_US     (TRIG_US),
        .US_PER_CM   (US_PER_CM),
        .TIMEOUT_US  (TIMEOUT_US),
        .HOLDOFF_US  (HOLDOFF_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .echo         (echo),
        .trig         (trig),
        .distance_out (distance_out),
        .done         (done),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one cycle from IDLE and confirm trig/busy rise after that edge
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_trig", 32'(trig), 32'd1);
    endtask

    // Count trigger width, ending on the first cycle of WAIT_ECHO
    task automatic trig_phase();
        int cnt;
        cnt = 0;
        while (trig && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("trig_width", 32'(cnt), 32'(TRIG_US * CLKS_PER_US));
    endtask

    task automatic wait_done(input int bound, output int cnt);
        cnt = 0;
        while (!done && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("holdoff_end", 32'(busy), 32'd0);
    endtask

    // One full measurement with echo rising delay_us after trig falls
    task automatic measure(input string tag, input int delay_us, input int width_us, input int exp_cm);
        int lat;
        do_start();
        trig_phase();
        cycles(delay_us * int'(CLKS_PER_US));
        echo = 1'b1;
        cycles(width_us * int'(CLKS_PER_US));
        echo = 1'b0;
        wait_done(50, lat);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_dist"}, 32'(distance_out), 32'(exp_cm));
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_busy_hold"}, 32'(busy), 32'd1);
        wait_idle();
    endtask

    initial begin
        int cnt;
        int trig_seen;
        int done_seen;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        cycles(3);
        rst = 1'b0;

        // Reset values and quiet idle
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_dist", 32'(distance_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        trig_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (trig || busy || done) trig_seen++;
        end
        check("idle_quiet", 32'(trig_seen), 32'd0);

        // Distance conversions, including floor rounding
        measure("m2436", 100, 2436, 42);
        measure("m580", 100, 580, 10);
        measure("m1160", 100, 1160, 20);

        // No echo: timeout exactly TIMEOUT_US after trigger end
        do_start();
        trig_phase();
        wait_done(20000, cnt);
        check("noecho_latency", 32'(cnt), 32'(TIMEOUT_US * CLKS_PER_US));
        check("noecho_dist", 32'(distance_out), 32'hFFF);
        check("noecho_timeout", 32'(timeout), 32'd1);
        @(negedge clk);
        check("noecho_done_1cyc", 32'(done), 32'd0);
        cycles(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("holdoff_start_trig", 32'(trig), 32'd0);
        check("holdoff_start_busy", 32'(busy), 32'd1);
        wait_idle();
        cycles(3);
        check("holdoff_not_queued", 32'(busy), 32'd0);
        check("holdoff_dist_held", 32'(distance_out), 32'hFFF);

        // Start after holdoff accepted
        measure("m637", 100, 637, 10);

        // Echo stuck high past the width limit
        do_start();
        trig_phase();
        cycles(100 * int'(CLKS_PER_US));
        echo = 1'b1;
        wait_done(20000, cnt);
        check("stuck_done", 32'(done), 32'd1);
        check("stuck_dist", 32'(distance_out), 32'hFFF);
        check("stuck_timeout", 32'(timeout), 32'd1);
        echo = 1'b0;
        wait_idle();

        // Rebuild a non-zero result, then reset mid-MEASURE
        measure("m_pre_rst", 50, 1160, 20);
        do_start();
        trig_phase();
        cycles(40);
        echo = 1'b1;
        cycles(500);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        echo = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_trig", 32'(trig), 32'd0);
        check("mrst_dist", 32'(distance_out), 32'd0);
        check("mrst_timeout", 32'(timeout), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        check("mrst_no_done", 32'(done_seen), 32'd0);

        // Two-cycle echo glitch while waiting for the echo
        do_start();
        trig_phase();
        cycles(20);
        echo = 1'b1;
        cycles(2);
        echo = 1'b0;
`ifdef RANGER_GLITCH_FILTER_EN
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("glitch_filtered", 32'(done_seen), 32'd0);
        check("glitch_busy", 32'(busy), 32'd1);
        wait_done(20000, cnt);
        check("glitch_to_dist", 32'(distance_out), 32'hFFF);
        check("glitch_to_timeout", 32'(timeout), 32'd1);
`else
        wait_done(50, cnt);
        check("glitch_latency", 32'(cnt), 32'd3);
        check("glitch_dist", 32'(distance_out), 32'd0);
        check("glitch_timeout", 32'(timeout), 32'd0);
`endif
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
